mul_share_arb: RTL and testbench
================================

Name: mul_share_arb

Overview:
- Round-robin arbiter/sequencer that shares one sequential Booth radix-4 multiplier among NUM_REQ requesters.
- Captures one request's operands, holds the multiplier's valid high for the whole operation, waits for done, and returns the product with the requester ID through a valid/ready response port.
- Sits between the requester ports and the multiplier instance in the datapath top level.

Parameters:
- NUM_REQ, 4, number of requesters (2..16).
- ID_W, 2, requester ID width; must equal clog2(NUM_REQ).
- WIDTH_M, 8, multiplicand width (signed two's complement).
- WIDTH_R, 8, multiplier width (signed two's complement, even).
- TO_CYC, 64, watchdog limit in cycles; used only with the optional feature.

Ports:
- clk, input, 1, clock; all logic on rising edge.
- rstn, input, 1, asynchronous active-low reset.
- req_vld, input, NUM_REQ, per-requester request valid.
- req_rdy, output, NUM_REQ, per-requester accept; at most one bit high.
- req_a, input, NUM_REQ*WIDTH_M, packed multiplicands; requester i uses bits [i*WIDTH_M +: WIDTH_M].
- req_b, input, NUM_REQ*WIDTH_R, packed multipliers; packed the same way.
- resp_vld, output, 1, response valid.
- resp_rdy, input, 1, response consumer ready.
- resp_id, output, ID_W, requester index of the response.
- resp_data, output, WIDTH_M+WIDTH_R, signed product.
- resp_err, output, 1, timeout flag.
- mul_vld_in, output, 1, multiplier valid; the multiplier aborts if this drops mid-operation.
- mul_a, output, WIDTH_M, multiplicand to the multiplier.
- mul_b, output, WIDTH_R, multiplier operand to the multiplier.
- mul_out, input, WIDTH_M+WIDTH_R, multiplier product.
- mul_done, input, 1, multiplier done.

Behaviour:
- Reset (rstn low, asynchronous): all outputs 0, state IDLE, rr_ptr=0, operand/ID/result registers 0. Reset mid-operation aborts the operation: mul_vld_in drops with reset and no response is produced.

- State IDLE:
  - Combinational grant: scan req_vld from rr_ptr upward with wrap; the first set bit g gets req_rdy[g]=1.
  - req_rdy is all zero in every other state.
  - On a handshake (req_vld[g]&req_rdy[g]): latch req_a/req_b slice g into mul_a/mul_b, latch g into resp_id, set rr_ptr=(g+1) mod NUM_REQ, go to RUN.
  - No valid request: stay in IDLE; rr_ptr unchanged.

- State RUN:
  - mul_vld_in=1; mul_a/mul_b stable (registered, unchanged).
  - On mul_done=1: register mul_out into resp_data, go to DRAIN.
  - mul_done sampled in the same cycle as the handshake is ignored.

- State DRAIN:
  - One cycle with mul_vld_in=0; this returns the multiplier to idle and clears its done. Then go to RESP.

- State RESP:
  - resp_vld=1; resp_id/resp_data/resp_err held stable until resp_rdy.
  - On resp_vld&resp_rdy: go to IDLE. resp_vld is 0 in IDLE, so back-to-back responses have at least a 1-cycle gap.

- mul_vld_in is registered: high exactly in the cycles the FSM is in RUN.
- Latency: grant to resp_vld = T_mul + 2 cycles, where T_mul is cycles from mul_vld_in rising to mul_done; for 8x8, T_mul = 10.
- Throughput: one operation at a time; no overlap.
- req_vld dropping while in RUN/DRAIN/RESP has no effect. A requester that keeps req_vld high after grant is served again only after the other active requesters.
- Fairness: any continuously asserted request is granted within NUM_REQ operations.
- resp_data is mul_out passed through unchanged; product width is WIDTH_M+WIDTH_R, signed.

Optional Feature:
- Macro MUL_SHARE_ARB_TIMEOUT_EN.
- Defined:
  - A cycle counter runs in RUN and resets to 0 on entry.
  - If it reaches TO_CYC without mul_done: resp_data=0, resp_err=1, go to DRAIN, then RESP as normal.
  - resp_err clears on the handshake.
- Not defined:
  - No counter logic is built; resp_err is tied 0.
  - RUN waits for mul_done indefinitely.

Test Plan:
- Single request: requester 2, a=-3 (8'hFD), b=5 -> req_rdy[2] for 1 cycle; resp_vld 12 cycles after grant with resp_id=2, resp_data=16'hFFF1, resp_err=0.
- All four requesters held valid, each with a=i+1, b=7, resp_rdy=1 -> grant order 0,1,2,3,0; products 7,14,21,28; never two req_rdy bits high.
- Corner operands: a=-128, b=-128 -> 16'h4000; a=127, b=-128 -> 16'hC080; a=0, b=-1 -> 0.
- Response backpressure: resp_rdy=0 for 20 cycles after resp_vld -> resp_vld/id/data stable; no req_rdy asserted; mul_vld_in=0; the next grant is on the cycle after resp_rdy returns to IDLE.
- Reset pulse 3 cycles into RUN -> mul_vld_in, resp_vld and req_rdy go to 0 immediately. After release, requester 1 with a=2, b=3 gives resp_data=6 and rr_ptr restarts at 0.
- With MUL_SHARE_ARB_TIMEOUT_EN, TO_CYC=16, mul_done held 0 -> resp_vld 18 cycles after grant with resp_err=1, resp_data=0. Without the macro, resp_err stays 0 and no response is produced.

Source files
------------

// File: rtl/mul_share_arb.sv
// mul_share_arb: round-robin sequencer that lends one sequential Booth radix-4
// multiplier to NUM_REQ requesters. It accepts one request at a time and holds
// the multiplier valid until done. The product and the requester index are then
// returned through a valid/ready response port.
//
// Optional build macro: MUL_SHARE_ARB_TIMEOUT_EN adds a RUN-state watchdog.
// If mul_done does not arrive within TO_CYC cycles, the watchdog returns a
// zero product with resp_err set.
module mul_share_arb #(
   parameter int NUM_REQ = 4,
   parameter int ID_W    = 2,
   parameter int WIDTH_M = 8,
   parameter int WIDTH_R = 8,
   parameter int TO_CYC  = 64
) (
   input  logic                         clk,
   input  logic                         rstn,
   input  logic [NUM_REQ-1:0]           req_vld,
   output logic [NUM_REQ-1:0]           req_rdy,
   input  logic [NUM_REQ*WIDTH_M-1:0]   req_a,
   input  logic [NUM_REQ*WIDTH_R-1:0]   req_b,
   output logic                         resp_vld,
   input  logic                         resp_rdy,
   output logic [ID_W-1:0]              resp_id,
   output logic [WIDTH_M+WIDTH_R-1:0]   resp_data,
   output logic                         resp_err,
   output logic                         mul_vld_in,
   output logic [WIDTH_M-1:0]           mul_a,
   output logic [WIDTH_R-1:0]           mul_b,
   input  logic [WIDTH_M+WIDTH_R-1:0]   mul_out,
   input  logic                         mul_done
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2,
      RESP  = 2'd3
   } state_t;

   state_t           state;
   state_t           state_nxt;
   logic [ID_W-1:0]  rr_ptr;
   logic [ID_W-1:0]  grant_id;
   logic [ID_W-1:0]  scan_idx;
   logic [ID_W:0]    scan_sum;
   logic             grant_any;
   logic             grant_ok;
   logic             timeout_hit;

   if (ID_W != $clog2(NUM_REQ)) begin : g_bad_id_w
      $error("mul_share_arb: ID_W must equal clog2(NUM_REQ)");
   end
   if (TO_CYC < 2) begin : g_bad_to_cyc
      $error("mul_share_arb: TO_CYC must be at least 2");
   end

   // Scan the request vector from rr_ptr upward with wrap and pick the first active requester.
   always_comb begin
      grant_any = 1'b0;
      grant_id  = '0;
      scan_sum  = '0;
      scan_idx  = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         scan_sum = {1'b0, rr_ptr} + (ID_W+1)'(k);
         if (scan_sum >= (ID_W+1)'(NUM_REQ)) begin
            scan_sum = scan_sum - (ID_W+1)'(NUM_REQ);
         end
         scan_idx = scan_sum[ID_W-1:0];
         if (!grant_any && req_vld[scan_idx]) begin
            grant_any = 1'b1;
            grant_id  = scan_idx;
         end
      end
   end

   // Grant only while idle and out of reset, so req_rdy drops with rstn and stays one-hot.
   always_comb begin
      grant_ok = rstn && (state == IDLE) && grant_any;
      req_rdy  = '0;
      if (grant_ok) begin
         req_rdy[grant_id] = 1'b1;
      end
   end

   // Next-state logic: mul_done wins over a watchdog expiry that lands in the same cycle.
   always_comb begin
      state_nxt = state;
      resp_vld  = (state == RESP);
      case (state)
         IDLE:    if (grant_ok) state_nxt = RUN;
         RUN:     if (mul_done || timeout_hit) state_nxt = DRAIN;
         DRAIN:   state_nxt = RESP;
         RESP:    if (resp_rdy) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // State, pointer, operand and result registers; mul_vld_in mirrors "next state is RUN".
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state      <= IDLE;
         rr_ptr     <= '0;
         mul_vld_in <= 1'b0;
         mul_a      <= '0;
         mul_b      <= '0;
         resp_id    <= '0;
         resp_data  <= '0;
      end else begin
         state      <= state_nxt;
         mul_vld_in <= (state_nxt == RUN);
         if (grant_ok) begin
            mul_a   <= req_a[grant_id*WIDTH_M +: WIDTH_M];
            mul_b   <= req_b[grant_id*WIDTH_R +: WIDTH_R];
            resp_id <= grant_id;
            if (grant_id == ID_W'(NUM_REQ-1)) begin
               rr_ptr <= '0;
            end else begin
               rr_ptr <= grant_id + 1'b1;
            end
         end
         if (state == RUN) begin
            if (mul_done) begin
               resp_data <= mul_out;
            end else if (timeout_hit) begin
               resp_data <= '0;
            end
         end
      end
   end

`ifdef MUL_SHARE_ARB_TIMEOUT_EN
   localparam int CNT_W = $clog2(TO_CYC + 1);

   logic [CNT_W-1:0] to_cnt;
   logic             err_q;

   assign timeout_hit = (state == RUN) && !mul_done && (to_cnt == CNT_W'(TO_CYC - 1));
   assign resp_err    = err_q;

   // Watchdog counts cycles spent in RUN from zero; the error flag lives until the response handshake.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         to_cnt <= '0;
         err_q  <= 1'b0;
      end else begin
         if (state != RUN) begin
            to_cnt <= '0;
         end else begin
            to_cnt <= to_cnt + 1'b1;
         end
         if (timeout_hit) begin
            err_q <= 1'b1;
         end else if ((state == RESP) && resp_rdy) begin
            err_q <= 1'b0;
         end
      end
   end
`else
   assign timeout_hit = 1'b0;
   assign resp_err    = 1'b0;
`endif

endmodule

// File: tb/tb_mul_share_arb.sv
// tb_mul_share_arb: directed-vector bench for mul_share_arb. It contains a
// behavioural model of the multiplier: done arrives in the 10th cycle of valid.
// Expected responses are queued when a request is issued. A monitor pops the
// queue and compares each entry whenever a response handshake occurs.
module tb_mul_share_arb;

   localparam int NUM_REQ = 4;
   localparam int ID_W    = 2;
   localparam int WM      = 8;
   localparam int WR      = 8;
   localparam int PW      = WM + WR;
   localparam int TO      = 16;

   typedef struct packed {
      logic [ID_W-1:0] id;
      logic [PW-1:0]   data;
      logic            err;
   } exp_t;

   logic                    clk = 1'b0;
   logic                    rstn;
   logic [NUM_REQ-1:0]      req_vld;
   logic [NUM_REQ-1:0]      req_rdy;
   logic [NUM_REQ*WM-1:0]   req_a;
   logic [NUM_REQ*WR-1:0]   req_b;
   logic                    resp_vld;
   logic                    resp_rdy;
   logic [ID_W-1:0]         resp_id;
   logic [PW-1:0]           resp_data;
   logic                    resp_err;
   logic                    mul_vld_in;
   logic [WM-1:0]           mul_a;
   logic [WR-1:0]           mul_b;
   logic [PW-1:0]           mul_out;
   logic                    mul_done;

   logic                    stall;
   logic [3:0]              mcnt;
   exp_t                    expq[$];
   int                      checks = 0;
   int                      errors = 0;

   mul_share_arb #(
      .NUM_REQ(NUM_REQ), .ID_W(ID_W), .WIDTH_M(WM), .WIDTH_R(WR), .TO_CYC(TO)
   ) dut (
      .clk(clk), .rstn(rstn),
      .req_vld(req_vld), .req_rdy(req_rdy), .req_a(req_a), .req_b(req_b),
      .resp_vld(resp_vld), .resp_rdy(resp_rdy), .resp_id(resp_id),
      .resp_data(resp_data), .resp_err(resp_err),
      .mul_vld_in(mul_vld_in), .mul_a(mul_a), .mul_b(mul_b),
      .mul_out(mul_out), .mul_done(mul_done)
   );

   // Free-running clock.
   always #5 clk = ~clk;

   // Multiplier model: clears whenever valid is low. The done signal rises in the
   // 10th cycle of valid unless the model is stalled.
   always @(posedge clk) begin
      if (!mul_vld_in) begin
         mcnt     <= 4'd0;
         mul_done <= 1'b0;
         mul_out  <= '0;
      end else begin
         mul_out <= $signed(mul_a) * $signed(mul_b);
         if (mcnt != 4'hF) mcnt <= mcnt + 4'd1;
         if (!stall && mcnt >= 4'd8) mul_done <= 1'b1;
      end
   end

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %0h, wanted %0h at %0t", name, actual, expected, $time);
      end
   endtask

   // Monitor: one-hot grant check every cycle. On each response handshake,
   // compare the response against the oldest expectation in the queue.
   always @(negedge clk) begin
      exp_t e;
      if (rstn) begin
         checkOutput("rdy_onehot", 32'($countones(req_rdy) <= 1), 32'd1);
         if (resp_vld && resp_rdy) begin
            if (expq.size() == 0) begin
               checkOutput("unexpected_resp", {30'd0, resp_id}, 32'hFFFF_FFFF);
            end else begin
               e = expq.pop_front();
               checkOutput("resp_id",   32'(resp_id),   32'(e.id));
               checkOutput("resp_data", 32'(resp_data), 32'(e.data));
               checkOutput("resp_err",  32'(resp_err),  32'(e.err));
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Waits (bounded) for a grant, checks it targets the expected requester, then steps through the handshake edge.
   task automatic waitGrant(input int id);
      int n;
      n = 0;
      @(negedge clk);
      while (req_rdy == '0 && n < 100) begin
         tick();
         @(negedge clk);
         n++;
      end
      checkOutput("grant", 32'(req_rdy), 32'd1 << id);
      tick();
   endtask

   // Issues one request from requester id and optionally queues its expected response.
   task automatic applyStimulus(input int id, input logic [WM-1:0] a, input logic [WR-1:0] b,
                                input logic [PW-1:0] expData, input logic expErr,
                                input bit push, input bit hold);
      if (push) expq.push_back(exp_t'{ID_W'(id), expData, expErr});
      req_a[id*WM +: WM] = a;
      req_b[id*WR +: WR] = b;
      req_vld[id] = 1'b1;
      waitGrant(id);
      if (!hold) req_vld[id] = 1'b0;
   endtask

   // Counts cycles from the grant cycle until resp_vld, and samples the first post-grant cycle.
   task automatic waitResp(output int n, output logic [NUM_REQ-1:0] rdy1, output logic vld1);
      n = 1;
      @(negedge clk);
      rdy1 = req_rdy;
      vld1 = mul_vld_in;
      while (!resp_vld && n < 200) begin
         @(negedge clk);
         n++;
      end
   endtask

   // Bounded overall run time.
   initial begin
      #300000;
      $display("[TB] FAIL global_timeout: simulation did not finish");
      $fatal(1, "[TB] timeout");
   end

   initial begin
      int                 n;
      logic [NUM_REQ-1:0] rdy1;
      logic               vld1;

      rstn = 1'b0; req_vld = '0; req_a = '0; req_b = '0; resp_rdy = 1'b1; stall = 1'b0;
      repeat (3) tick();
      @(negedge clk);
      checkOutput("rst_resp_vld", 32'(resp_vld), 32'd0);
      checkOutput("rst_mul_vld",  32'(mul_vld_in), 32'd0);
      checkOutput("rst_resp_data", 32'(resp_data), 32'd0);
      checkOutput("rst_mul_ab", {16'd0, mul_a, mul_b}, 32'd0);
      checkOutput("rst_resp_id_err", {30'd0, resp_id} + 32'(resp_err), 32'd0);
      tick();
      rstn = 1'b1;
      tick();

      $display("[TB] all four requesters held valid");
      req_a = {8'd4, 8'd3, 8'd2, 8'd1};
      req_b = {8'd7, 8'd7, 8'd7, 8'd7};
      expq.push_back(exp_t'{2'd0, 16'd7, 1'b0});
      expq.push_back(exp_t'{2'd1, 16'd14, 1'b0});
      expq.push_back(exp_t'{2'd2, 16'd21, 1'b0});
      expq.push_back(exp_t'{2'd3, 16'd28, 1'b0});
      expq.push_back(exp_t'{2'd0, 16'd7, 1'b0});
      req_vld = 4'hF;
      for (int k = 0; k < 5; k++) waitGrant(k % 4);
      req_vld = '0;
      waitResp(n, rdy1, vld1);
      tick();

      $display("[TB] single request from requester 2");
      applyStimulus(2, 8'hFD, 8'h05, 16'hFFF1, 1'b0, 1'b1, 1'b0);
      waitResp(n, rdy1, vld1);
      checkOutput("latency", 32'(n), 32'd12);
      checkOutput("rdy_after_grant", 32'(rdy1), 32'd0);
      checkOutput("mul_vld_run", 32'(vld1), 32'd1);
      tick();

      $display("[TB] corner operands");
      applyStimulus(3, 8'h80, 8'h80, 16'h4000, 1'b0, 1'b1, 1'b0);
      waitResp(n, rdy1, vld1);
      checkOutput("latency_c1", 32'(n), 32'd12);
      tick();
      applyStimulus(0, 8'h7F, 8'h80, 16'hC080, 1'b0, 1'b1, 1'b0);
      waitResp(n, rdy1, vld1);
      tick();
      applyStimulus(1, 8'h00, 8'hFF, 16'h0000, 1'b0, 1'b1, 1'b0);
      waitResp(n, rdy1, vld1);
      tick();

      $display("[TB] response backpressure");
      resp_rdy = 1'b0;
      applyStimulus(2, 8'h06, 8'hF9, 16'hFFD6, 1'b0, 1'b1, 1'b0);
      expq.push_back(exp_t'{2'd3, 16'h0063, 1'b0});
      req_a[3*WM +: WM] = 8'h09;
      req_b[3*WR +: WR] = 8'h0B;
      req_vld[3] = 1'b1;
      waitResp(n, rdy1, vld1);
      checkOutput("latency_bp", 32'(n), 32'd12);
      for (int i = 0; i < 20; i++) begin
         checkOutput("bp_vld",  32'(resp_vld), 32'd1);
         checkOutput("bp_id",   32'(resp_id), 32'd2);
         checkOutput("bp_data", 32'(resp_data), 32'hFFD6);
         checkOutput("bp_rdy",  32'(req_rdy), 32'd0);
         checkOutput("bp_mvld", 32'(mul_vld_in), 32'd0);
         @(negedge clk);
      end
      @(posedge clk);
      #1;
      resp_rdy = 1'b1;
      @(negedge clk);
      tick();
      @(negedge clk);
      checkOutput("grant_after_bp", 32'(req_rdy), 32'b1000);
      tick();
      req_vld[3] = 1'b0;
      waitResp(n, rdy1, vld1);
      tick();

      $display("[TB] reset pulse during RUN");
      applyStimulus(2, 8'h11, 8'h22, 16'h0000, 1'b0, 1'b0, 1'b0);
      tick();
      tick();
      req_a[1*WM +: WM] = 8'd2; req_b[1*WR +: WR] = 8'd3;
      req_a[3*WM +: WM] = 8'd5; req_b[3*WR +: WR] = 8'd5;
      req_vld = 4'b1010;
      rstn = 1'b0;
      #1;
      checkOutput("rst_run_mvld", 32'(mul_vld_in), 32'd0);
      checkOutput("rst_run_rvld", 32'(resp_vld), 32'd0);
      checkOutput("rst_run_rdy",  32'(req_rdy), 32'd0);
      repeat (3) tick();
      rstn = 1'b1;
      expq.push_back(exp_t'{2'd1, 16'd6, 1'b0});
      expq.push_back(exp_t'{2'd3, 16'd25, 1'b0});
      waitGrant(1);
      req_vld[1] = 1'b0;
      waitResp(n, rdy1, vld1);
      checkOutput("latency_rst", 32'(n), 32'd12);
      tick();
      waitGrant(3);
      req_vld[3] = 1'b0;
      waitResp(n, rdy1, vld1);
      tick();

      $display("[TB] multiplier never signals done");
      stall = 1'b1;
`ifdef MUL_SHARE_ARB_TIMEOUT_EN
      applyStimulus(0, 8'h05, 8'h05, 16'h0000, 1'b1, 1'b1, 1'b0);
      waitResp(n, rdy1, vld1);
      checkOutput("latency_to", 32'(n), 32'd18);
      checkOutput("to_err", 32'(resp_err), 32'd1);
      tick();
      @(negedge clk);
      checkOutput("to_err_clear", 32'(resp_err), 32'd0);
      stall = 1'b0;
      tick();
`else
      applyStimulus(0, 8'h05, 8'h05, 16'h0000, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         checkOutput("noto_rvld", 32'(resp_vld), 32'd0);
         checkOutput("noto_err",  32'(resp_err), 32'd0);
         checkOutput("noto_mvld", 32'(mul_vld_in), 32'd1);
      end
      tick();
      rstn = 1'b0;
      stall = 1'b0;
      repeat (2) tick();
      rstn = 1'b1;
      tick();
`endif

      $display("[TB] recovery request");
      applyStimulus(2, 8'hF0, 8'h10, 16'hFF00, 1'b0, 1'b1, 1'b0);
      waitResp(n, rdy1, vld1);
      checkOutput("latency_end", 32'(n), 32'd12);
      tick();
      repeat (2) tick();
      checkOutput("queue_empty", 32'(expq.size()), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
